// File: rtl/servo_pwm_if.sv
// Angle/enable command bundle into the servo PWM generator and its PWM/frame outputs.
interface servo_pwm_if;
    logic       enable;
    logic [7:0] angle1;
    logic [7:0] angle2;
    logic [7:0] angle3;
    logic [7:0] angle4;
    logic       pwm1;
    logic       pwm2;
    logic       pwm3;
    logic       pwm4;
    logic       frame_tick;

    modport master (
        output enable, angle1, angle2, angle3, angle4,
        input  pwm1, pwm2, pwm3, pwm4, frame_tick
    );

    modport slave (
        input  enable, angle1, angle2, angle3, angle4,
        output pwm1, pwm2, pwm3, pwm4, frame_tick
    );
endinterface

// File: rtl/servo_pwm_gen.sv
// Four-channel 50 Hz servo PWM generator: per-frame angle latch with optional slew limit,
// shared microsecond prescaler and frame counter, one lane instance per servo.
module servo_pwm_chan #(
    parameter int UW       = 15,
    parameter int MIN_US   = 1000,
    parameter int MAX_US   = 2000,
    parameter int SLEW_DEG = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          boundary,
    input  logic          en_latch,
    input  logic [UW-1:0] us_cnt,
    input  logic [7:0]    angle,
    output logic          pwm
);
    localparam int SPAN  = MAX_US - MIN_US;
    localparam int W_MID = MIN_US + (90 * SPAN) / 180;

    logic [7:0]    applied;
    logic [7:0]    target;
    logic [7:0]    applied_nxt;
    logic [31:0]   width_calc;
    logic [UW-1:0] width;

    assign target = (angle > 8'd180) ? 8'd180 : angle;

    always_comb begin
        applied_nxt = target;
        if (SLEW_DEG != 0) begin
            if ((target > applied) && ((target - applied) > 8'(SLEW_DEG)))
                applied_nxt = applied + 8'(SLEW_DEG);
            else if ((applied > target) && ((applied - target) > 8'(SLEW_DEG)))
                applied_nxt = applied - 8'(SLEW_DEG);
        end
    end

    // 32-bit product keeps 180*SPAN exact before the floor division
    assign width_calc = 32'(MIN_US) + (32'(applied_nxt) * 32'(SPAN)) / 32'd180;

    always_ff @(posedge clk) begin
        if (rst) begin
            applied <= 8'd90;
            width   <= UW'(W_MID);
            pwm     <= 1'b0;
        end else begin
            if (boundary) begin
                applied <= applied_nxt;
                width   <= UW'(width_calc);
            end
            pwm <= en_latch && (us_cnt < width);
        end
    end
endmodule

module servo_pwm_gen #(
    parameter int CLK_HZ   = 50000000,
    parameter int FRAME_US = 20000,
    parameter int MIN_US   = 1000,
    parameter int MAX_US   = 2000,
    parameter int SLEW_DEG = 5
) (
    input  logic        clk,
    input  logic        rst,
    servo_pwm_if.slave  bus
);
    localparam int NUM_LANES = 4;
    localparam int PRESC     = CLK_HZ / 1000000;
    localparam int PW        = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam int UW        = $clog2(FRAME_US);

    logic [PW-1:0]                 prescaler;
    logic [UW-1:0]                 us_cnt;
    logic                          us_tick;
    logic                          boundary;
    logic                          en_latch;
    logic                          frame_tick;
    logic [NUM_LANES-1:0][7:0]     angle;
    logic [NUM_LANES-1:0]          pwm;

    assign us_tick  = (prescaler == PW'(PRESC - 1));
    assign boundary = us_tick && (us_cnt == UW'(FRAME_US - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            prescaler  <= '0;
            us_cnt     <= '0;
            en_latch   <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            prescaler  <= us_tick ? '0 : prescaler + 1'b1;
            if (us_tick)
                us_cnt <= boundary ? '0 : us_cnt + 1'b1;
            frame_tick <= boundary;
            // enable only takes effect from a frame start, never mid-pulse
            if (boundary)
                en_latch <= bus.enable;
        end
    end

    assign angle = {bus.angle4, bus.angle3, bus.angle2, bus.angle1};

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_ch
        servo_pwm_chan #(
            .UW       (UW),
            .MIN_US   (MIN_US),
            .MAX_US   (MAX_US),
            .SLEW_DEG (SLEW_DEG)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .boundary (boundary),
            .en_latch (en_latch),
            .us_cnt   (us_cnt),
            .angle    (angle[i]),
            .pwm      (pwm[i])
        );
    end

    assign bus.pwm1       = pwm[0];
    assign bus.pwm2       = pwm[1];
    assign bus.pwm3       = pwm[2];
    assign bus.pwm4       = pwm[3];
    assign bus.frame_tick = frame_tick;
endmodule
